// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan reader: glyph patterns (active-low),
// segment bit positions and the frame FSM state type.
package seven_seg_pkg;

    localparam logic [6:0] SEG_GLYPH_0 = 7'h01;
    localparam logic [6:0] SEG_GLYPH_1 = 7'h4F;
    localparam logic [6:0] SEG_GLYPH_2 = 7'h12;
    localparam logic [6:0] SEG_GLYPH_3 = 7'h06;
    localparam logic [6:0] SEG_GLYPH_4 = 7'h4C;
    localparam logic [6:0] SEG_GLYPH_5 = 7'h24;
    localparam logic [6:0] SEG_GLYPH_6 = 7'h20;
    localparam logic [6:0] SEG_GLYPH_7 = 7'h0F;
    localparam logic [6:0] SEG_GLYPH_8 = 7'h00;
    localparam logic [6:0] SEG_GLYPH_9 = 7'h04;
    localparam logic [6:0] SEG_GLYPH_A = 7'h08;
    localparam logic [6:0] SEG_GLYPH_B = 7'h60;
    localparam logic [6:0] SEG_GLYPH_C = 7'h31;
    localparam logic [6:0] SEG_GLYPH_D = 7'h42;
    localparam logic [6:0] SEG_GLYPH_E = 7'h30;
    localparam logic [6:0] SEG_GLYPH_F = 7'h38;
    localparam logic [6:0] SEG_BLANK   = 7'h7F;

    localparam int unsigned SEG_A = 6;
    localparam int unsigned SEG_B = 5;
    localparam int unsigned SEG_C = 4;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 2;
    localparam int unsigned SEG_F = 1;
    localparam int unsigned SEG_G = 0;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } frame_state_t;

endpackage

// File: rtl/seven_seg_pattern_to_hex.sv
// Combinational reverse lookup from an active-low segment pattern to a hex nibble.
// With SEG_READER_BLANK_EN the all-off pattern is accepted as nibble 0.
module seven_seg_pattern_to_hex
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       legal
);

    always_comb begin
        nibble = 4'h0;
        legal  = 1'b1;
        case (seg)
            SEG_GLYPH_0: nibble = 4'h0;
            SEG_GLYPH_1: nibble = 4'h1;
            SEG_GLYPH_2: nibble = 4'h2;
            SEG_GLYPH_3: nibble = 4'h3;
            SEG_GLYPH_4: nibble = 4'h4;
            SEG_GLYPH_5: nibble = 4'h5;
            SEG_GLYPH_6: nibble = 4'h6;
            SEG_GLYPH_7: nibble = 4'h7;
            SEG_GLYPH_8: nibble = 4'h8;
            SEG_GLYPH_9: nibble = 4'h9;
            SEG_GLYPH_A: nibble = 4'hA;
            SEG_GLYPH_B: nibble = 4'hB;
            SEG_GLYPH_C: nibble = 4'hC;
            SEG_GLYPH_D: nibble = 4'hD;
            SEG_GLYPH_E: nibble = 4'hE;
            SEG_GLYPH_F: nibble = 4'hF;
`ifdef SEG_READER_BLANK_EN
            SEG_BLANK:   nibble = 4'h0;
`endif
            default:     legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_reader.sv
// Recovers hex digits from a multiplexed active-low seven-segment bus and presents
// whole frames on valid/ready. SEG_READER_BLANK_EN adds blank-digit support and blank_mask.
module seven_seg_scan_reader
    import seven_seg_pkg::*;
#(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     digit_sel,
    output logic [4*DIGITS-1:0]   value,
    output logic                  value_valid,
    input  logic                  value_ready,
    output logic                  pattern_err,
`ifdef SEG_READER_BLANK_EN
    output logic [DIGITS-1:0]     blank_mask,
`endif
    output logic                  overrun
);

    localparam int unsigned KEY_W = DIGITS + 7;
    localparam int unsigned RUN_W = 8;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

    logic [6:0]          seg_s1, seg_s2;
    logic [DIGITS-1:0]   sel_s1, sel_s2;
    logic [KEY_W-1:0]    prev_key;
    logic [RUN_W-1:0]    run;
    logic [DIGITS-1:0]   seen;
    logic [4*DIGITS-1:0] slots;
    frame_state_t        state;

    logic [KEY_W-1:0]    key_c;
    logic [RUN_W-1:0]    run_next_c;
    logic                capture_c;
    logic                frame_done_c;
    logic [DIGITS-1:0]   seen_next_c;
    logic [3:0]          nibble_c;
    logic                legal_c;

`ifdef SEG_READER_BLANK_EN
    logic [DIGITS-1:0]   blank_slots;
    logic                blank_c;
    assign blank_c = (seg_s2 == SEG_BLANK);
`endif

    seven_seg_pattern_to_hex u_decode (
        .seg    (seg_s2),
        .nibble (nibble_c),
        .legal  (legal_c)
    );

    // Run-length filter; capture fires only on the cycle the run first reaches the threshold.
    always_comb begin
        key_c      = {sel_s2, seg_s2};
        run_next_c = run;
        if (!$onehot(~sel_s2))
            run_next_c = '0;
        else if (key_c != prev_key)
            run_next_c = RUN_W'(1);
        else if (run != RUN_MAX)
            run_next_c = run + RUN_W'(1);
        capture_c    = (run_next_c == RUN_MAX) && (run != RUN_MAX);
        frame_done_c = &seen;
        // Every completed frame clears seen, whether it was loaded or discarded.
        seen_next_c  = frame_done_c ? '0 : seen;
        if (capture_c && legal_c)
            seen_next_c = seen_next_c | ~sel_s2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1      <= '1;
            seg_s2      <= '1;
            sel_s1      <= '1;
            sel_s2      <= '1;
            prev_key    <= '1;
            run         <= '0;
            seen        <= '0;
            slots       <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            pattern_err <= 1'b0;
            overrun     <= 1'b0;
            state       <= COLLECT;
`ifdef SEG_READER_BLANK_EN
            blank_slots <= '0;
            blank_mask  <= '0;
`endif
        end else begin
            seg_s1      <= seg_in;
            seg_s2      <= seg_s1;
            sel_s1      <= digit_sel;
            sel_s2      <= sel_s1;
            prev_key    <= key_c;
            run         <= run_next_c;
            seen        <= seen_next_c;
            pattern_err <= capture_c && !legal_c;
            overrun     <= 1'b0;

            for (int i = 0; i < int'(DIGITS); i++) begin
                if (capture_c && legal_c && !sel_s2[i]) begin
                    slots[4*i +: 4] <= nibble_c;
`ifdef SEG_READER_BLANK_EN
                    blank_slots[i]  <= blank_c;
`endif
                end
            end

            case (state)
                COLLECT: begin
                    if (frame_done_c) begin
                        value       <= slots;
                        value_valid <= 1'b1;
                        state       <= HOLD;
`ifdef SEG_READER_BLANK_EN
                        blank_mask  <= blank_slots;
`endif
                    end
                end
                HOLD: begin
                    if (value_ready) begin
                        if (frame_done_c) begin
                            value      <= slots;
`ifdef SEG_READER_BLANK_EN
                            blank_mask <= blank_slots;
`endif
                        end else begin
                            value_valid <= 1'b0;
                            state       <= COLLECT;
                        end
                    end else if (frame_done_c) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_reader.sv
// Self-checking bench for seven_seg_scan_reader: directed scenarios plus a randomized
// scan checked against a dwell-level reference model.
module tb_seven_seg_scan_reader;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned S      = 4;
    localparam int unsigned VW     = 4 * DIGITS;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    seg_in;
    logic [3:0]    digit_sel;
    logic [VW-1:0] value;
    logic          value_valid;
    logic          value_ready;
    logic          pattern_err;
    logic          overrun;
`ifdef SEG_READER_BLANK_EN
    logic [3:0]    blank_mask;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int perr_cnt = 0;
    int ovr_cnt  = 0;
    logic prev_valid = 1'b0;
    logic [VW-1:0] frames[$];

    logic [6:0] glyphs [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    always #5 clk = ~clk;

    seven_seg_scan_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .digit_sel   (digit_sel),
        .value       (value),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .pattern_err (pattern_err),
`ifdef SEG_READER_BLANK_EN
        .blank_mask  (blank_mask),
`endif
        .overrun     (overrun)
    );

    // Records each rising value_valid and counts the error pulses.
    always @(negedge clk) begin
        if (value_valid && !prev_valid) frames.push_back(value);
        if (pattern_err) perr_cnt++;
        if (overrun) ovr_cnt++;
        prev_valid = value_valid;
    end

    function automatic logic ref_decode(input logic [6:0] p, output logic [3:0] n);
        n = 4'h0;
        for (int k = 0; k < 16; k++)
            if (glyphs[k] == p) begin
                n = 4'(k);
                return 1'b1;
            end
`ifdef SEG_READER_BLANK_EN
        if (p == 7'h7F) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic show(input logic [3:0] sel, input logic [6:0] seg, input int n);
        digit_sel = sel;
        seg_in    = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic show_digit(input int d, input logic [6:0] seg, input int n);
        logic [3:0] s;
        s    = 4'hF;
        s[d] = 1'b0;
        show(s, seg, n);
    endtask

    task automatic idle(input int n);
        show(4'hF, 7'h7F, n);
    endtask

    task automatic do_reset();
        digit_sel   = 4'hF;
        seg_in      = 7'h7F;
        value_ready = 1'b0;
        rst         = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        frames.delete();
    endtask

    task automatic scan4(input logic [6:0] g0, input logic [6:0] g1,
                         input logic [6:0] g2, input logic [6:0] g3);
        show_digit(0, g0, 10);
        show_digit(1, g1, 10);
        show_digit(2, g2, 10);
        show_digit(3, g3, 10);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        digit_sel = 4'hF; seg_in = 7'h7F; value_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (value !== 16'h0) begin n_fail++; $display("FAIL reset_value got %h want %h", value, 16'h0); end
        n_checks++; if (value_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", value_valid); end
        n_checks++; if (pattern_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr got %b want 0", pattern_err); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
        rst = 1'b0;
    endtask

    task automatic test_clean_scan();
        int p0;
        do_reset();
        p0 = perr_cnt;
        show_digit(0, glyphs[1], 10);
        show_digit(1, glyphs[2], 10);
        show_digit(2, glyphs[3], 10);
        digit_sel = 4'b0111; seg_in = glyphs[4];
        repeat (S + 2) @(negedge clk);
        n_checks++; if (value_valid !== 1'b0) begin n_fail++; $display("FAIL frame_latency_early got %b want 0", value_valid); end
        @(negedge clk);
        n_checks++; if (value_valid !== 1'b1) begin n_fail++; $display("FAIL frame_latency_edge got %b want 1", value_valid); end
        n_checks++; if (value !== 16'h4321) begin n_fail++; $display("FAIL clean_value got %h want 4321", value); end
        repeat (10 - (S + 3)) @(negedge clk);
        idle(4);
        n_checks++; if (value_valid !== 1'b1) begin n_fail++; $display("FAIL clean_hold got %b want 1", value_valid); end
        n_checks++; if (perr_cnt - p0 !== 0) begin n_fail++; $display("FAIL clean_perr got %0d want 0", perr_cnt - p0); end
        value_ready = 1'b1;
        @(negedge clk);
        value_ready = 1'b0;
        n_checks++; if (value_valid !== 1'b0) begin n_fail++; $display("FAIL clean_accept got %b want 0", value_valid); end
    endtask

    task automatic test_glitch();
        int p0;
        do_reset();
        p0 = perr_cnt;
        show_digit(0, glyphs[0], 10);
        show_digit(1, glyphs[1], 4);
        show_digit(1, 7'h00, 2);
        show_digit(1, glyphs[1], 6);
        show_digit(2, glyphs[2], 10);
        show_digit(3, glyphs[3], 10);
        idle(4);
        n_checks++; if (value !== 16'h3210 || value_valid !== 1'b1) begin n_fail++; $display("FAIL glitch_value got %h/%b want 3210/1", value, value_valid); end
        n_checks++; if (perr_cnt - p0 !== 0) begin n_fail++; $display("FAIL glitch_perr got %0d want 0", perr_cnt - p0); end
    endtask

    task automatic test_illegal();
        int p0;
        do_reset();
        p0 = perr_cnt;
        scan4(glyphs[0], glyphs[1], 7'h7E, glyphs[3]);
        idle(4);
        n_checks++; if (perr_cnt - p0 !== 1) begin n_fail++; $display("FAIL illegal_perr got %0d want 1", perr_cnt - p0); end
        n_checks++; if (value_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_noframe got %b want 0", value_valid); end
        show_digit(2, glyphs[2], 10);
        idle(4);
        n_checks++; if (value !== 16'h3210 || value_valid !== 1'b1) begin n_fail++; $display("FAIL illegal_recover got %h/%b want 3210/1", value, value_valid); end
    endtask

    task automatic test_overrun();
        int o0;
        do_reset();
        o0 = ovr_cnt;
        scan4(glyphs[1], glyphs[2], glyphs[3], glyphs[4]);
        idle(4);
        scan4(glyphs[5], glyphs[6], glyphs[7], glyphs[8]);
        idle(4);
        n_checks++; if (ovr_cnt - o0 !== 1) begin n_fail++; $display("FAIL overrun_count got %0d want 1", ovr_cnt - o0); end
        n_checks++; if (value !== 16'h4321 || value_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_hold got %h/%b want 4321/1", value, value_valid); end
        value_ready = 1'b1;
        @(negedge clk);
        value_ready = 1'b0;
        n_checks++; if (value_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_accept got %b want 0", value_valid); end
        idle(4);
        n_checks++; if (value_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_discard got %b want 0", value_valid); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        scan4(glyphs[1], glyphs[2], glyphs[3], glyphs[4]);
        idle(4);
        show_digit(0, glyphs[10], 10);
        show_digit(1, glyphs[11], 10);
        digit_sel = 4'b1011; seg_in = glyphs[12];
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (value !== 16'h0 || value_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_outputs got %h/%b want 0000/0", value, value_valid); end
        n_checks++; if (pattern_err !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL midreset_pulses got %b/%b want 0/0", pattern_err, overrun); end
        @(negedge clk);
        rst = 1'b0;
        show_digit(2, glyphs[12], 10);
        show_digit(3, glyphs[13], 10);
        idle(4);
        n_checks++; if (value_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_seen_cleared got %b want 0", value_valid); end
        show_digit(0, glyphs[10], 10);
        show_digit(1, glyphs[11], 10);
        idle(4);
        n_checks++; if (value !== 16'hDCBA || value_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_frame got %h/%b want dcba/1", value, value_valid); end
    endtask

    task automatic test_blank();
        int p0;
        do_reset();
        p0 = perr_cnt;
        scan4(glyphs[5], glyphs[5], glyphs[5], 7'h7F);
        idle(4);
`ifdef SEG_READER_BLANK_EN
        n_checks++; if (value !== 16'h0555 || value_valid !== 1'b1) begin n_fail++; $display("FAIL blank_value got %h/%b want 0555/1", value, value_valid); end
        n_checks++; if (blank_mask !== 4'b1000) begin n_fail++; $display("FAIL blank_mask got %b want 1000", blank_mask); end
        n_checks++; if (perr_cnt - p0 !== 0) begin n_fail++; $display("FAIL blank_perr got %0d want 0", perr_cnt - p0); end
`else
        n_checks++; if (value_valid !== 1'b0) begin n_fail++; $display("FAIL blank_noframe got %b want 0", value_valid); end
        n_checks++; if (perr_cnt - p0 !== 1) begin n_fail++; $display("FAIL blank_perr got %0d want 1", perr_cnt - p0); end
`endif
    endtask

    task automatic test_random();
        logic [VW-1:0] exp_frames[$];
        logic [VW-1:0] slots_m;
        logic [3:0]    seen_m, sel, nib;
        logic [6:0]    pat;
        logic [10:0]   prev_key;
        int            len, zeros, idx, exp_perr, p0, o0, nf;
        do_reset();
        value_ready = 1'b1;
        p0 = perr_cnt; o0 = ovr_cnt;
        slots_m = '0; seen_m = '0; exp_perr = 0;
        prev_key = {4'hF, 7'h7F};
        for (int t = 0; t < 150; t++) begin
            do begin
                if ($urandom_range(0, 9) == 0) sel = 4'($urandom_range(0, 15));
                else begin sel = 4'hF; sel[$urandom_range(0, 3)] = 1'b0; end
                case ($urandom_range(0, 9))
                    8:       pat = 7'($urandom_range(0, 127));
                    9:       pat = 7'h7F;
                    default: pat = glyphs[$urandom_range(0, 15)];
                endcase
            end while ({sel, pat} == prev_key);
            prev_key = {sel, pat};
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, S - 1)) : int'($urandom_range(S, S + 6));
            zeros = 0; idx = 0;
            for (int i = 0; i < 4; i++) if (!sel[i]) begin zeros++; idx = i; end
            if (zeros == 1 && len >= int'(S)) begin
                if (ref_decode(pat, nib)) begin
                    slots_m[4*idx +: 4] = nib;
                    seen_m[idx] = 1'b1;
                    if (seen_m == 4'hF) begin
                        exp_frames.push_back(slots_m);
                        seen_m = '0;
                    end
                end else exp_perr++;
            end
            show(sel, pat, len);
        end
        idle(12);
        nf = frames.size();
        n_checks++; if (nf !== exp_frames.size()) begin n_fail++; $display("FAIL rand_frame_count got %0d want %0d", nf, exp_frames.size()); end
        for (int i = 0; i < nf && i < exp_frames.size(); i++) begin
            n_checks++; if (frames[i] !== exp_frames[i]) begin n_fail++; $display("FAIL rand_frame[%0d] got %h want %h", i, frames[i], exp_frames[i]); end
        end
        n_checks++; if (perr_cnt - p0 !== exp_perr) begin n_fail++; $display("FAIL rand_perr got %0d want %0d", perr_cnt - p0, exp_perr); end
        n_checks++; if (ovr_cnt - o0 !== 0) begin n_fail++; $display("FAIL rand_overrun got %0d want 0", ovr_cnt - o0); end
        value_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        digit_sel = 4'hF; seg_in = 7'h7F; value_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_clean_scan();
        test_glitch();
        test_illegal();
        test_overrun();
        test_reset_mid_frame();
        test_blank();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
